// File: rtl/token_to_ascii.sv
// token_to_ascii: walks a 16-bit token buffer (operands and operator codes)
// and writes the equivalent ASCII expression one character at a time,
// ending with CR. Negative operands get a leading '-'. Digits are produced
// MSB first by repeated subtraction, with leading zeros suppressed.
//
//  state  | meaning
//  -------+-------------------------------------------------------------
//  IDLE   | pointers/flags cleared, waiting for En
//  FETCH  | R_Pointer presented to the token RAM (or divert to CR on abort)
//  WAIT   | RAM latency, token captured into tok_q at the end of the cycle
//  DECODE | classify tok_q: end / operator / operand (sign, magnitude)
//  SIGN   | write '-' for a negative operand
//  DIGIT  | one subtract of the current decimal weight per cycle
//  EMIT   | write char_q (operator or finished digit)
//  CR     | write 0x0D
//  DONE   | Finish high, R_Pointer parked on the end token
module token_to_ascii #(
    parameter int PTR_W   = 8,
    parameter int MAX_TOK = 255
) (
    input  logic             Sysclk,
    input  logic             Rst,
    input  logic             En,
    input  logic [15:0]      Token_In,
    output logic [PTR_W-1:0] R_Pointer,
    output logic [15:0]      Outstr,
    output logic             W_En,
    output logic [PTR_W-1:0] W_Pointer,
    output logic             Finish,
    output logic             Err
);

    localparam int CNT_W = $clog2(MAX_TOK + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_SIGN, S_DIGIT, S_EMIT, S_CR, S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      tok_q;
    logic [CNT_W-1:0] tok_left;
    logic [16:0]      mag;
    logic [2:0]       place;
    logic [3:0]       digit;
    logic             started;
    logic             more_digits;
    logic [7:0]       char_q;
    logic             err_q;

    logic             is_end;
    logic             is_op;
    logic [7:0]       op_char;
    logic [16:0]      weight;
    logic             can_sub;
    logic             digit_shows;
    logic             wr_req;
    logic [7:0]       wr_char;

    // Token classification of the captured word
    always_comb begin
        is_end  = (tok_q == 16'h8001);
        is_op   = 1'b1;
        op_char = 8'h00;
        case (tok_q)
            16'h7FFF: op_char = 8'h2B;
            16'h7FFE: op_char = 8'h2D;
            16'h8002: op_char = 8'h2A;
            16'h8003: op_char = 8'h2F;
            16'h7FFC: op_char = 8'h28;
            16'h7FFD: op_char = 8'h29;
            default:  is_op   = 1'b0;
        endcase
    end

    // Decimal weight of the digit position currently being resolved
    always_comb begin
        case (place)
            3'd0:    weight = 17'd10000;
            3'd1:    weight = 17'd1000;
            3'd2:    weight = 17'd100;
            3'd3:    weight = 17'd10;
            default: weight = 17'd1;
        endcase
        can_sub     = (mag >= weight);
        digit_shows = (digit != 4'd0) || started || (place == 3'd4);
    end

    // State register; En low forces a synchronous return to IDLE
    always_ff @(posedge Sysclk or posedge Rst) begin
        if (Rst)
            state <= S_IDLE;
        else if (!En)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = err_q ? S_CR : S_WAIT;
            S_WAIT:   state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_end)
                    state_nxt = S_CR;
                else if (is_op)
                    state_nxt = S_EMIT;
                else if (tok_q[15])
                    state_nxt = S_SIGN;
                else
                    state_nxt = S_DIGIT;
            end
            S_SIGN:   state_nxt = S_DIGIT;
            S_DIGIT:  state_nxt = (!can_sub && digit_shows) ? S_EMIT : S_DIGIT;
            // Abort also routes through FETCH so CR never lands right after a write
            S_EMIT:   state_nxt = more_digits ? S_DIGIT : S_FETCH;
            S_CR:     state_nxt = S_DONE;
            S_DONE:   state_nxt = S_DONE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Output decode: write request and character per state
    always_comb begin
        wr_req  = 1'b0;
        wr_char = 8'h00;
        Finish  = (state == S_DONE);
        case (state)
            S_SIGN: begin wr_req = 1'b1; wr_char = 8'h2D;  end
            S_EMIT: begin wr_req = 1'b1; wr_char = char_q; end
            S_CR:   begin wr_req = 1'b1; wr_char = 8'h0D;  end
            default: ;
        endcase
    end

    assign Err = err_q;

    // Datapath: pointers, write port, token capture and digit extraction
    always_ff @(posedge Sysclk or posedge Rst) begin
        if (Rst) begin
            R_Pointer   <= '0;
            W_Pointer   <= '0;
            Outstr      <= '0;
            W_En        <= 1'b0;
            err_q       <= 1'b0;
            tok_q       <= '0;
            tok_left    <= '0;
            mag         <= '0;
            place       <= '0;
            digit       <= '0;
            started     <= 1'b0;
            more_digits <= 1'b0;
            char_q      <= '0;
        end else if (!En) begin
            R_Pointer   <= '0;
            W_Pointer   <= '0;
            Outstr      <= '0;
            W_En        <= 1'b0;
            err_q       <= 1'b0;
            tok_q       <= '0;
            tok_left    <= '0;
            mag         <= '0;
            place       <= '0;
            digit       <= '0;
            started     <= 1'b0;
            more_digits <= 1'b0;
            char_q      <= '0;
        end else begin
            W_En <= wr_req;
            if (wr_req)
                Outstr <= {8'h00, wr_char};
            if (W_En)
                W_Pointer <= W_Pointer + PTR_W'(1);

            case (state)
                S_IDLE: tok_left <= CNT_W'(MAX_TOK);
                S_WAIT: tok_q <= Token_In;
                S_DECODE: begin
                    if (tok_left != '0)
                        tok_left <= tok_left - CNT_W'(1);
                    more_digits <= 1'b0;
                    char_q      <= op_char;
                    place       <= '0;
                    digit       <= '0;
                    started     <= 1'b0;
                    // 17-bit negate so 0x8000 becomes 32768
                    mag <= tok_q[15] ? (17'd0 - {1'b1, tok_q}) : {1'b0, tok_q};
                end
                S_DIGIT: begin
                    if (can_sub) begin
                        mag   <= mag - weight;
                        digit <= digit + 4'd1;
                    end else begin
                        char_q      <= 8'h30 + {4'h0, digit};
                        digit       <= '0;
                        more_digits <= (place != 3'd4);
                        if (digit_shows)
                            started <= 1'b1;
                        if (place != 3'd4)
                            place <= place + 3'd1;
                    end
                end
                S_EMIT: begin
                    if (!more_digits) begin
                        if (tok_left != '0)
                            R_Pointer <= R_Pointer + PTR_W'(1);
                        else
                            err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_token_to_ascii.sv
// Self-checking bench for token_to_ascii: directed streams plus random
// streams, each compared against a string-formatting reference model.
module tb_token_to_ascii;

    localparam int PTR_W   = 8;
    localparam int MAX_TOK = 6;

    logic             Sysclk = 1'b0;
    logic             Rst;
    logic             En;
    logic [15:0]      Token_In;
    logic [PTR_W-1:0] R_Pointer;
    logic [15:0]      Outstr;
    logic             W_En;
    logic [PTR_W-1:0] W_Pointer;
    logic             Finish;
    logic             Err;

    token_to_ascii #(.PTR_W(PTR_W), .MAX_TOK(MAX_TOK)) dut (
        .Sysclk   (Sysclk),
        .Rst      (Rst),
        .En       (En),
        .Token_In (Token_In),
        .R_Pointer(R_Pointer),
        .Outstr   (Outstr),
        .W_En     (W_En),
        .W_Pointer(W_Pointer),
        .Finish   (Finish),
        .Err      (Err)
    );

    always #5 Sysclk = ~Sysclk;

    // Token RAM with one cycle read latency
    logic [15:0] mem [0:255];
    always @(posedge Sysclk) Token_In <= mem[R_Pointer];

    // Write-port monitor
    byte unsigned got_chr[$];
    int           got_adr[$];
    int           back2back = 0;
    int           hi_nonzero = 0;
    logic         prev_wen = 1'b0;
    always @(negedge Sysclk) begin
        if (W_En) begin
            got_chr.push_back(Outstr[7:0]);
            got_adr.push_back(int'(W_Pointer));
            if (Outstr[15:8] != 8'h00) hi_nonzero <= hi_nonzero + 1;
        end
        if (prev_wen && W_En) back2back <= back2back + 1;
        prev_wen <= W_En;
    end

    int n_cmp = 0;
    int n_err = 0;

    byte unsigned exp_q[$];
    bit           exp_err;
    int           exp_end;
    int           base;
    int           b2b_base;
    int           hi_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: text rendering of the token list, abort after MAX_TOK reads
    function automatic void build_model();
        bit    done;
        string s;
        logic [15:0] t;
        exp_q.delete();
        exp_err = 1'b0;
        exp_end = -1;
        done    = 1'b0;
        for (int i = 0; i <= MAX_TOK && !done; i++) begin
            if (i == MAX_TOK) begin
                exp_q.push_back(8'h0D);
                exp_err = 1'b1;
                done = 1'b1;
            end else begin
                t = mem[i];
                case (t)
                    16'h8001: begin exp_q.push_back(8'h0D); exp_end = i; done = 1'b1; end
                    16'h7FFF: exp_q.push_back("+");
                    16'h7FFE: exp_q.push_back("-");
                    16'h8002: exp_q.push_back("*");
                    16'h8003: exp_q.push_back("/");
                    16'h7FFC: exp_q.push_back("(");
                    16'h7FFD: exp_q.push_back(")");
                    default: begin
                        s = $sformatf("%0d", int'($signed(t)));
                        for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
                    end
                endcase
            end
        end
    endfunction

    function automatic bit is_special(input logic [15:0] t);
        return (t inside {16'h7FFC, 16'h7FFD, 16'h7FFE, 16'h7FFF, 16'h8001, 16'h8002, 16'h8003});
    endfunction

    function automatic logic [15:0] rand_tok();
        logic [15:0] ops [6];
        logic [15:0] edge_v [4];
        logic [15:0] t;
        ops    = '{16'h7FFF, 16'h7FFE, 16'h8002, 16'h8003, 16'h7FFC, 16'h7FFD};
        edge_v = '{16'h8000, 16'h7FFB, 16'h0000, 16'hFFFF};
        case ($urandom_range(0, 5))
            0: t = ops[$urandom_range(0, 5)];
            1: t = 16'($urandom_range(0, 20));
            2: t = 16'(-$urandom_range(1, 200));
            3: t = edge_v[$urandom_range(0, 3)];
            default: begin
                t = 16'($urandom);
                while (is_special(t)) t = 16'($urandom);
            end
        endcase
        return t;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic start_and_wait(input string tag);
        int cyc;
        @(negedge Sysclk);
        En = 1'b0;
        @(negedge Sysclk);
        base     = got_chr.size();
        b2b_base = back2back;
        hi_base  = hi_nonzero;
        En = 1'b1;
        cyc = 0;
        while (!Finish && cyc < 3000) begin
            @(negedge Sysclk);
            cyc++;
        end
        chk({tag, "_finish_reached"}, 32'(Finish), 32'd1);
        repeat (3) @(negedge Sysclk);
    endtask

    task automatic check_stream(input string tag);
        int nw;
        build_model();
        nw = got_chr.size() - base;
        chk({tag, "_nwrites"}, 32'(nw), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < nw; k++) begin
            chk($sformatf("%s_chr%0d", tag, k), 32'(got_chr[base + k]), 32'(exp_q[k]));
            chk($sformatf("%s_adr%0d", tag, k), 32'(got_adr[base + k]), 32'(k));
        end
        chk({tag, "_wptr"}, 32'(W_Pointer), 32'(exp_q.size()));
        chk({tag, "_err"}, 32'(Err), 32'(exp_err));
        if (exp_end >= 0) chk({tag, "_rptr"}, 32'(R_Pointer), 32'(exp_end));
        chk({tag, "_b2b"}, 32'(back2back - b2b_base), 32'd0);
        chk({tag, "_hibyte"}, 32'(hi_nonzero - hi_base), 32'd0);
        repeat (4) @(negedge Sysclk);
        chk({tag, "_finish_held"}, 32'(Finish), 32'd1);
        chk({tag, "_no_extra"}, 32'(got_chr.size() - base), 32'(exp_q.size()));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_rptr0"}, 32'(R_Pointer), 32'd0);
        chk({tag, "_wptr0"}, 32'(W_Pointer), 32'd0);
        chk({tag, "_out0"}, 32'(Outstr), 32'd0);
        chk({tag, "_wen0"}, 32'(W_En), 32'd0);
        chk({tag, "_fin0"}, 32'(Finish), 32'd0);
        chk({tag, "_err0"}, 32'(Err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int len;
        Rst = 1'b1;
        En  = 1'b0;
        clear_mem();
        #23;
        chk_cleared("reset");
        Rst = 1'b0;
        @(negedge Sysclk);
        chk_cleared("idle");

        // T1: 12+3
        clear_mem();
        mem[0] = 16'h000C; mem[1] = 16'h7FFF; mem[2] = 16'h0003; mem[3] = 16'h8001;
        start_and_wait("t1");
        check_stream("t1");

        // T2: (-5)*0
        clear_mem();
        mem[0] = 16'h7FFC; mem[1] = 16'hFFFB; mem[2] = 16'h7FFD;
        mem[3] = 16'h8002; mem[4] = 16'h0000; mem[5] = 16'h8001;
        start_and_wait("t2");
        check_stream("t2");

        // T3: -32768/32763
        clear_mem();
        mem[0] = 16'h8000; mem[1] = 16'h8003; mem[2] = 16'h7FFB; mem[3] = 16'h8001;
        start_and_wait("t3");
        check_stream("t3");

        // T4: En dropped in the middle of 12345
        clear_mem();
        mem[0] = 16'h3039; mem[1] = 16'h8001;
        @(negedge Sysclk);
        En = 1'b0;
        @(negedge Sysclk);
        base = got_chr.size();
        En = 1'b1;
        cyc = 0;
        while ((got_chr.size() - base) < 2 && cyc < 500) begin
            @(negedge Sysclk);
            cyc++;
        end
        chk("t4_mid_number", 32'(got_chr.size() - base), 32'd2);
        En = 1'b0;
        @(posedge Sysclk);
        #1;
        chk_cleared("t4");
        start_and_wait("t4r");
        check_stream("t4r");

        // T5: async reset mid-stream
        clear_mem();
        mem[0] = 16'h3039; mem[1] = 16'h7FFE; mem[2] = 16'h0007; mem[3] = 16'h8001;
        @(negedge Sysclk);
        En = 1'b0;
        @(negedge Sysclk);
        En = 1'b1;
        repeat (14) @(negedge Sysclk);
        #2;
        Rst = 1'b1;
        #1;
        chk_cleared("t5");
        @(negedge Sysclk);
        Rst = 1'b0;
        start_and_wait("t5r");
        check_stream("t5r");

        // T6: no end token, abort after MAX_TOK tokens
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = (i % 2 == 0) ? 16'(i + 1) : 16'h7FFF;
        start_and_wait("t6");
        check_stream("t6");

        // Random streams, some without an end token
        for (int r = 0; r < 14; r++) begin
            clear_mem();
            len = $urandom_range(0, 7);
            for (int i = 0; i < 10; i++) mem[i] = rand_tok();
            if (len < 7) mem[len] = 16'h8001;
            start_and_wait($sformatf("rnd%0d", r));
            check_stream($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
